// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD line constants, scheduler state type and a character helper.
// Contents: LCD_CHARS, LCD_LINE_W, ASCII_SPACE, lcd_state_e {IDLE, GRANT, SHOW},
// line_char(line, n) returning character n (1 = leftmost) of a 128-bit line.
package lcd_pkg;
  localparam int LCD_CHARS = 16;
  localparam int LCD_LINE_W = LCD_CHARS * 8;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [1:0] {IDLE, GRANT, SHOW} lcd_state_e;
  function automatic logic [7:0] line_char(input logic [LCD_LINE_W-1:0] line, input int n);
    return line[(LCD_CHARS - n) * 8 +: 8];
  endfunction
endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: combinational rotate-priority pick starting at ptr.
// Ports: req (level requests), ptr (first index checked), winner (picked index),
// any_req (at least one request asserted).
module lcd_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         winner,
  output logic               any_req
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [IW-1:0] idx;
  // Scan from the farthest offset down so the nearest asserted index after ptr wins.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) winner = 3'(idx);
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/lcd_page_scheduler.sv
// lcd_page_scheduler: round-robin owner of the LCD line-2 buffer with a minimum frame dwell.
// Ports: CLK, RESETN (sync, active low), REQ/REQ_DATA (per-requester request and 16-char text),
// FRAME_DONE (end of LCD refresh frame), GNT (one-cycle one-hot grant), LINE_DATA (held text),
// OWNER (requester shown), PAGE_VALID (a page was captured), BUSY (GRANT or SHOW).
// Optional macro LCD_PRIO_EN: requester 0 wins arbitration and aborts a dwell owned by others.
module lcd_page_scheduler
  import lcd_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int DWELL_FRAMES = 2,
  parameter int CHARS        = 16
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*LCD_LINE_W-1:0] REQ_DATA,
  input  logic                          FRAME_DONE,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [LCD_LINE_W-1:0]         LINE_DATA,
  output logic [2:0]                    OWNER,
  output logic                          PAGE_VALID,
  output logic                          BUSY
);
  if (CHARS != LCD_CHARS) begin : g_chars_check
    $error("lcd_page_scheduler: CHARS must be 16");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_check
    $error("lcd_page_scheduler: NUM_REQ must be 2..8");
  end
  lcd_state_e state, state_nx;
  logic [2:0] ptr, win_q, win, pick, nxt_ptr;
  logic [7:0] frames;
  logic any_req, preempt, adv_ptr, dwell_done;
  lcd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(REQ),
    .ptr(ptr),
    .winner(win),
    .any_req(any_req)
  );
`ifdef LCD_PRIO_EN
  assign pick = REQ[0] ? 3'd0 : win;
  assign preempt = (state == SHOW) && REQ[0] && (OWNER != 3'd0);
  // Urgent grants leave the rotation where it was.
  assign adv_ptr = (win_q != 3'd0);
`else
  assign pick = win;
  assign preempt = 1'b0;
  assign adv_ptr = 1'b1;
`endif
  assign nxt_ptr = (win_q == 3'(NUM_REQ - 1)) ? 3'd0 : win_q + 3'd1;
  assign dwell_done = FRAME_DONE && (frames + 8'd1 == 8'(DWELL_FRAMES));
  assign BUSY = (state != IDLE);
  always_comb begin
    state_nx = (state == IDLE) ? (any_req ? GRANT : IDLE)
             : (state == GRANT) ? SHOW
             : preempt ? GRANT
             : dwell_done ? IDLE : SHOW;
    GNT = (state == GRANT) ? NUM_REQ'(1) << win_q : '0;
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= IDLE;
      win_q      <= '0;
      ptr        <= '0;
      frames     <= '0;
      LINE_DATA  <= {LCD_CHARS{ASCII_SPACE}};
      OWNER      <= '0;
      PAGE_VALID <= 1'b0;
    end else begin
      state <= state_nx;
      // Entering GRANT from SHOW only happens on an urgent abort, which always serves requester 0.
      if (state_nx == GRANT) win_q <= (state == SHOW) ? 3'd0 : pick;
      if (state == GRANT) begin
        LINE_DATA  <= REQ_DATA[int'(win_q) * LCD_LINE_W +: LCD_LINE_W];
        OWNER      <= win_q;
        PAGE_VALID <= 1'b1;
        frames     <= '0;
        if (adv_ptr) ptr <= nxt_ptr;
      end else if (state == SHOW && FRAME_DONE) begin
        frames <= frames + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_page_scheduler.sv
// tb_lcd_page_scheduler: directed scoreboard bench for lcd_page_scheduler.
module tb_lcd_page_scheduler;
  import lcd_pkg::*;
  localparam int N = 3;
  localparam logic [127:0] D0     = "KEY ENTRY       ";
  localparam logic [127:0] D1     = "LEA KEY 0123456 ";
  localparam logic [127:0] D2     = "CIPHER   ABCDEF0";
  localparam logic [127:0] D2_ALT = "CIPHER CHANGED!!";
  localparam logic [127:0] BLANK  = {16{8'h20}};
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [N*128-1:0] REQ_DATA = '0;
  logic FRAME_DONE = 1'b0;
  logic [N-1:0] GNT;
  logic [127:0] LINE_DATA;
  logic [2:0] OWNER;
  logic PAGE_VALID, BUSY;
  typedef struct {
    logic [N-1:0] gnt;
    logic [127:0] data;
    logic [2:0]   owner;
    int           min_frames;
  } exp_t;
  exp_t sbq[$];
  exp_t cur;
  logic pend_v = 1'b0;
  int frames_since = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] g;
  logic [2:0] rr_owner [4];

  always #5 CLK = ~CLK;

  lcd_page_scheduler #(.NUM_REQ(N), .DWELL_FRAMES(2), .CHARS(16)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .REQ(REQ),
    .REQ_DATA(REQ_DATA),
    .FRAME_DONE(FRAME_DONE),
    .GNT(GNT),
    .LINE_DATA(LINE_DATA),
    .OWNER(OWNER),
    .PAGE_VALID(PAGE_VALID),
    .BUSY(BUSY)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [N-1:0] gn, input logic [127:0] d, input logic [2:0] o, input int mf);
    exp_t e;
    e.gnt = gn;
    e.data = d;
    e.owner = o;
    e.min_frames = mf;
    return e;
  endfunction

  // Monitor: pops an expectation on every grant, checks the captured page one cycle later,
  // and counts frames between grants to enforce the dwell.
  always @(negedge CLK) begin
    if (pend_v) begin
      check("line_data", LINE_DATA, cur.data);
      check("owner", {125'b0, OWNER}, {125'b0, cur.owner});
      check("page_valid", {127'b0, PAGE_VALID}, 1);
      pend_v = 1'b0;
    end
    if (!RESETN) frames_since = 0;
    else if (GNT != '0) begin
      if (sbq.size() == 0) check("unexpected_gnt", {125'b0, GNT}, 0);
      else begin
        cur = sbq.pop_front();
        check("gnt", {125'b0, GNT}, {125'b0, cur.gnt});
        check("dwell_frames", {127'b0, frames_since >= cur.min_frames}, 1);
        pend_v = 1'b1;
      end
      frames_since = 0;
    end else if (FRAME_DONE) frames_since++;
  end

  task automatic frame(input int gap);
    repeat (gap - 1) @(posedge CLK);
    #1 FRAME_DONE = 1'b1;
    @(posedge CLK);
    #1 FRAME_DONE = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, input logic drop, output logic [N-1:0] gg);
    gg = '0;
    for (int i = 0; i < budget && gg == '0; i++) begin
      @(negedge CLK);
      gg = GNT;
    end
    check("gnt_wait", {127'b0, gg != '0}, 1);
    @(posedge CLK);
    #1;
    if (drop) REQ = REQ & ~gg;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    REQ_DATA = {D2, D1, D0};
    RESETN = 1'b0;
    REQ = 3'b111;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_line", LINE_DATA, BLANK);
    check("rst_gnt", {125'b0, GNT}, 0);
    check("rst_valid", {127'b0, PAGE_VALID}, 0);
    check("rst_busy", {127'b0, BUSY}, 0);
    check("rst_owner", {125'b0, OWNER}, 0);
`ifdef LCD_PRIO_EN
    rr_owner = '{3'd0, 3'd0, 3'd0, 3'd0};
`else
    rr_owner = '{3'd0, 3'd1, 3'd2, 3'd0};
`endif
    for (int k = 0; k < 4; k++)
      sbq.push_back(mk(N'(1) << rr_owner[k], REQ_DATA[int'(rr_owner[k]) * 128 +: 128], rr_owner[k], k == 0 ? 0 : 2));
    @(posedge CLK);
    #1 RESETN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(20, 1'b0, g);
      if (k == 3) REQ = '0;
      frame(100);
      frame(100);
    end
    REQ = 3'b010;
    sbq.push_back(mk(3'b010, D1, 3'd1, 2));
    wait_gnt(20, 1'b1, g);
    check("char1", {120'b0, line_char(LINE_DATA, 1)}, {120'b0, 8'h4C});
    check("char16", {120'b0, line_char(LINE_DATA, 16)}, {120'b0, 8'h20});
    REQ = 3'b100;
    sbq.push_back(mk(3'b100, D2, 3'd2, 2));
    frame(20);
    repeat (3) begin
      @(negedge CLK);
      check("no_early_gnt", {125'b0, GNT}, 0);
    end
    frame(20);
    @(negedge CLK);
    check("idle_gap_gnt", {125'b0, GNT}, 0);
    check("idle_gap_busy", {127'b0, BUSY}, 0);
    @(negedge CLK);
    check("gnt_after_dwell", {125'b0, GNT}, 3'b100);
    @(posedge CLK);
    #1 REQ = '0;
    REQ_DATA[256 +: 128] = D2_ALT;
    repeat (3) @(negedge CLK);
    check("data_stable", LINE_DATA, D2);
    REQ_DATA[256 +: 128] = D2;
    frame(20);
    frame(20);
    @(posedge CLK);
    #1 REQ = 3'b100;
    sbq.push_back(mk(3'b100, D2, 3'd2, 2));
    @(posedge CLK);
    #1 FRAME_DONE = 1'b1;
    @(negedge CLK);
    check("gnt_with_frame", {125'b0, GNT}, 3'b100);
    @(posedge CLK);
    #1 FRAME_DONE = 1'b0;
    REQ = '0;
    frame(20);
    @(negedge CLK);
    check("dwell_hold_busy", {127'b0, BUSY}, 1);
    frame(20);
    @(negedge CLK);
    check("dwell_end_busy", {127'b0, BUSY}, 0);
    @(posedge CLK);
    #1 REQ = 3'b100;
    sbq.push_back(mk(3'b100, D2, 3'd2, 2));
    wait_gnt(20, 1'b1, g);
    frame(20);
    @(negedge CLK);
    check("show_owner", {125'b0, OWNER}, 2);
    @(posedge CLK);
    #1 RESETN = 1'b0;
    REQ = 3'b111;
    sbq.push_back(mk(3'b001, D0, 3'd0, 0));
    sbq.push_back(mk(3'b010, D1, 3'd1, 2));
    @(posedge CLK);
    #1 RESETN = 1'b1;
    @(negedge CLK);
    check("mid_rst_line", LINE_DATA, BLANK);
    check("mid_rst_busy", {127'b0, BUSY}, 0);
    check("mid_rst_valid", {127'b0, PAGE_VALID}, 0);
    check("mid_rst_owner", {125'b0, OWNER}, 0);
    wait_gnt(20, 1'b1, g);
    frame(20);
    frame(20);
    wait_gnt(20, 1'b1, g);
    frame(20);
    @(posedge CLK);
    #1 RESETN = 1'b0;
    REQ = 3'b111;
    sbq.push_back(mk(3'b001, D0, 3'd0, 0));
    @(posedge CLK);
    #1 RESETN = 1'b1;
    wait_gnt(20, 1'b1, g);
    check("rst_ptr_gnt", {125'b0, g}, 3'b001);
    REQ = '0;
    frame(20);
    frame(20);
    REQ = 3'b100;
    sbq.push_back(mk(3'b100, D2, 3'd2, 2));
    wait_gnt(20, 1'b1, g);
    repeat (2) @(posedge CLK);
    #1 REQ = 3'b001;
`ifdef LCD_PRIO_EN
    sbq.push_back(mk(3'b001, D0, 3'd0, 0));
    wait_gnt(2, 1'b1, g);
    check("prio_gnt", {125'b0, g}, 3'b001);
`else
    sbq.push_back(mk(3'b001, D0, 3'd0, 2));
    repeat (4) begin
      @(negedge CLK);
      check("no_preempt", {125'b0, GNT}, 0);
    end
    frame(20);
    frame(20);
    wait_gnt(5, 1'b1, g);
    check("late_gnt", {125'b0, g}, 3'b001);
`endif
    frame(20);
    frame(20);
    for (int i = 0; i < 200 && (sbq.size() != 0 || pend_v); i++) @(posedge CLK);
    check("scoreboard_drained", 128'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_page_scheduler.md
Name: lcd_page_scheduler

Overview:
- Shares the 16-character LCD line-2 text buffer among NUM_REQ requesters, e.g. key entry, plaintext view and ciphertext view of the LEA datapath.
- Arbitrates round-robin, snapshots the winner's 16 bytes into a held line register and keeps that page on screen for at least DWELL_FRAMES complete LCD refresh frames.
- Sits between the cipher/key logic and the LCD character driver. LINE_DATA feeds the driver's sixteen 8-bit line-2 inputs.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DWELL_FRAMES, 2, minimum number of FRAME_DONE pulses a granted page is held (legal range 1..255).
- CHARS, 16, characters per line. Fixed at 16; any other value is rejected at elaboration.

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  synchronous active-low reset.
- REQ  in  NUM_REQ  level request per requester.
- REQ_DATA  in  NUM_REQ*128  requester i text at bits [i*128 +: 128]; char 1 in the MS byte.
- FRAME_DONE  in  1  one-cycle pulse from the LCD driver at the end of each full refresh frame.
- GNT  out  NUM_REQ  one-hot, one-cycle grant pulse.
- LINE_DATA  out  128  held display text; char 1 = [127:120], char 16 = [7:0].
- OWNER  out  3  index of the requester currently shown.
- PAGE_VALID  out  1  1 once any page has been captured since reset.
- BUSY  out  1  1 while in GRANT or SHOW.

Behaviour:
- Reset, applied synchronously on a CLK edge with RESETN=0:
  - state=IDLE, GNT=0, LINE_DATA=all 8'h20 (spaces), OWNER=0, PAGE_VALID=0, BUSY=0.
  - Round-robin pointer=0, so requester 0 is checked first.
  - Frame counter=0.
- Reset asserted mid-SHOW discards the page and dwell immediately.
- States: IDLE, GRANT, SHOW.
- IDLE:
  - If REQ≠0, choose the first asserted index starting at the pointer, wrapping modulo NUM_REQ.
  - Go to GRANT, latching the winner index.
  - If REQ=0, stay in IDLE and keep LINE_DATA and OWNER unchanged (the last page stays displayed).
- GRANT (exactly 1 cycle):
  - GNT[winner]=1.
  - LINE_DATA <= REQ_DATA slice of the winner, sampled this cycle.
  - OWNER <= winner, PAGE_VALID <= 1.
  - Pointer <= (winner+1) mod NUM_REQ, frame counter <= 0.
  - Next state is SHOW.
  - A FRAME_DONE in this cycle is ignored.
- SHOW:
  - Each FRAME_DONE increments the frame counter.
  - When the counter reaches DWELL_FRAMES, go to IDLE; arbitration happens in that IDLE cycle.
  - The minimum gap between grants is therefore DWELL_FRAMES frames plus 1 cycle.
- Handshake:
  - A requester holds REQ high until it sees GNT.
  - REQ still high in the cycle after GNT counts as a new request. It will be served again only after the other pending requesters.
  - REQ dropped before its grant: no grant is issued and no error is raised.
  - REQ_DATA must be stable in the GRANT cycle. Changes after GNT do not affect the display.
- LINE_DATA, OWNER and PAGE_VALID are registered outputs. They change only in GRANT or on reset.
- Simultaneous requests: strict round-robin. With all requesters asserting continuously, the grant order is 0,1,2,0,...

Optional Feature:
- Macro: LCD_PRIO_EN.
- Defined:
  - Requester 0 is urgent, e.g. for error or alarm text.
  - In IDLE, REQ[0] beats round-robin.
  - In SHOW with OWNER≠0, REQ[0]=1 aborts the dwell; the next cycle is GRANT for requester 0.
  - The pointer is not advanced by urgent grants.
  - A dwell owned by requester 0 is not preemptible.
- Undefined: pure round-robin, no preemption. The REQ[0] abort logic is absent.

Decomposition:
- Package lcd_pkg holds:
  - LCD_CHARS=16 and LCD_LINE_W=128.
  - ASCII_SPACE=8'h20.
  - The scheduler state enum {IDLE, GRANT, SHOW}.
  - A helper function to extract character n from a 128-bit line.
- One sub-module, lcd_rr_arbiter: combinational rotate-priority pick. Inputs: REQ, pointer. Outputs: winner index, any_req.

Test Plan:
- Reset: RESETN=0 for 2 cycles with REQ=3'b111 → LINE_DATA=all 8'h20, GNT=0, PAGE_VALID=0; the first grant after release goes to requester 0.
- Single request: REQ=3'b010, REQ_DATA[1]="LEA KEY 0123456 " → GNT=3'b010 for one cycle, then LINE_DATA equals that text and OWNER=1; the next grant comes only after the 2nd FRAME_DONE.
- Round-robin: REQ=3'b111 held with FRAME_DONE every 100 cycles → grant order 0,1,2,0; no grant within 2 frames of the previous one.
- Frame in GRANT cycle: FRAME_DONE coincident with GNT → not counted; SHOW ends on the 2nd subsequent pulse.
- Mid-SHOW reset: RESETN=0 during SHOW with OWNER=2 → the next cycle shows LINE_DATA=spaces, BUSY=0, pointer=0.
- LCD_PRIO_EN: requester 2 showing, REQ[0] asserted → GNT=3'b001 within 2 cycles and OWNER=0. Without the macro, the grant waits for the full dwell.
